// File: rtl/updown_dir_ctrl.sv
// Direction controller for a WIDTH-bit up/down counter: debounced button toggle or auto ping-pong.
// Optional build macro DIR_CTRL_LOCK_EN adds a lock input that discards all toggle requests.
module updown_dir_ctrl #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TCNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn,
    input  logic              mode,
`ifdef DIR_CTRL_LOCK_EN
    input  logic              lock,
`endif
    input  logic [WIDTH-1:0]  count_in,
    output logic              up_down,
    output logic              dir_changed,
    output logic [TCNT_W-1:0] toggle_count
);

    localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DebLast  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] LimHiVal = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WIDTH-1:0] LimLoVal = WIDTH'(1);

    localparam logic [0:0] StDown = 1'b0;
    localparam logic [0:0] StUp   = 1'b1;

    logic              s1_q, s2_q;
    logic              deb_level_q, deb_level_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              deb_prev_q;
    logic              press_q, press_d;
    logic [0:0]        state_q, state_d;
    logic              dir_changed_q;
    logic [TCNT_W-1:0] toggle_count_q, toggle_count_d;
    logic              lim_hi, lim_lo, toggle_req, toggle;

    // Level is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_comb begin
        deb_cnt_d   = deb_cnt_q;
        deb_level_d = deb_level_q;
        if (s2_q == deb_level_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DebLast) begin
            deb_level_d = s2_q;
            deb_cnt_d   = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
    end

    assign press_d = deb_level_q & ~deb_prev_q;

    // Limits fire one count early so the registered direction lands as the counter hits MAX or 0.
    assign lim_hi     = mode & (state_q == StUp) & (count_in == LimHiVal);
    assign lim_lo     = mode & (state_q == StDown) & (count_in == LimLoVal);
    assign toggle_req = press_q | lim_hi | lim_lo;

`ifdef DIR_CTRL_LOCK_EN
    assign toggle = toggle_req & ~lock;
`else
    assign toggle = toggle_req;
`endif

    always_comb begin
        state_d        = state_q;
        toggle_count_d = toggle_count_q;
        if (toggle) begin
            state_d        = (state_q == StUp) ? StDown : StUp;
            toggle_count_d = toggle_count_q + TCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            deb_level_q    <= 1'b0;
            deb_cnt_q      <= '0;
            deb_prev_q     <= 1'b0;
            press_q        <= 1'b0;
            state_q        <= StUp;
            dir_changed_q  <= 1'b0;
            toggle_count_q <= '0;
        end else begin
            s1_q           <= btn;
            s2_q           <= s1_q;
            deb_level_q    <= deb_level_d;
            deb_cnt_q      <= deb_cnt_d;
            deb_prev_q     <= deb_level_q;
            press_q        <= press_d;
            state_q        <= state_d;
            dir_changed_q  <= toggle;
            toggle_count_q <= toggle_count_d;
        end
    end

    assign up_down      = (state_q == StUp);
    assign dir_changed  = dir_changed_q;
    assign toggle_count = toggle_count_q;

endmodule

// File: doc/updown_dir_ctrl.md
Name: updown_dir_ctrl

Overview:
- Direction controller directly upstream of the 4-bit up/down counter.
- Drives the counter's up_down input and reads back the counter's q as count_in.
- Manual mode: a debounced push-button toggles direction.
- Auto mode: direction reverses at the count limits so the counter ping-pongs 0..MAX without wrapping.

Parameters:
- WIDTH, 4, width of count_in; must match the counter.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a button level change; minimum 2.
- TCNT_W, 8, width of toggle_count.

Ports:
- clk  input  1  system clock; all state on posedge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- btn  input  1  raw push-button, asynchronous to clk, may bounce.
- mode  input  1  0 = manual toggle, 1 = auto bounce; sampled every cycle.
- count_in  input  WIDTH  counter q output.
- up_down  output  1  direction to counter: 1 = up, 0 = down; registered.
- dir_changed  output  1  one-cycle pulse, high in the same cycle up_down takes its new value.
- toggle_count  output  TCNT_W  number of direction changes since reset; wraps.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: up_down=1, dir_changed=0, toggle_count=0.
  - Internal state: sync flops=0, debounced level=0, debounce counter=0.
  - Release is synchronous to the next posedge.
- Synchronizer: two flops, btn→s1→s2. Only s2 is used downstream.
- Debouncer:
  - deb_cnt clears whenever s2==deb_level.
  - Otherwise deb_cnt increments.
  - At the DEBOUNCE_CYCLES-th consecutive edge with s2!=deb_level: deb_level<=s2 and deb_cnt<=0.
  - Glitches shorter than DEBOUNCE_CYCLES samples are rejected.
- Press event: registered rising edge of deb_level; one cycle wide. Falling edges are ignored.
- Manual-mode latency: btn held high and stable from edge E0 → up_down toggles at edge E0+DEBOUNCE_CYCLES+3. With default DEBOUNCE_CYCLES=4, that is 7 edges.
- Limit events (evaluated only when mode=1):
  - LIM_HI: up_down=1 and count_in==2^WIDTH-2 (14 at default).
  - LIM_LO: up_down=0 and count_in==1.
  - Turnaround is one cycle early on purpose: the registered up_down is then seen by the counter on the edge where it reaches MAX or 0. The counter therefore turns at 15 and 0 and never wraps.
- Direction FSM: two states, UP and DOWN, reset state UP.
  - Transition when any toggle request is present: press (either mode) or a limit event (mode=1).
  - On a transition: flip up_down, assert dir_changed for one cycle, increment toggle_count.
- Simultaneous press and limit event in the same cycle: exactly one flip, one increment.
- In auto mode, a press reverses direction mid-run; limit rules then apply from the new direction.
- mode change: takes effect on the edge it is sampled. No state is flushed. A pending debounce continues.
- count_in at the limit value with the wrong direction (e.g. up_down=0, count_in=14): no event.
- toggle_count arithmetic: modulo 2^TCNT_W, e.g. 255→0 at default.
- Reset mid-debounce or mid-pulse: all state cleared immediately; dir_changed drops asynchronously.

Optional Feature:
- Macro: DIR_CTRL_LOCK_EN.
- When defined:
  - Adds input port lock (1 bit), placed after mode.
  - While lock=1, all toggle requests are discarded: up_down holds, no dir_changed, toggle_count holds.
  - Synchronizer and debouncer keep running. A press whose event cycle falls inside lock is lost, not deferred.
  - Note: in auto mode with lock=1, the counter will wrap.
- When undefined: no lock port; behaviour as above.

Test Plan:
- Reset: rst=0 with btn toggling → up_down=1, dir_changed=0, toggle_count=0. Release rst, hold btn=0 for 20 cycles → outputs unchanged.
- Clean press, mode=0: btn 0→1 held 10 cycles → up_down 1→0 exactly 7 edges after btn first sampled high; dir_changed high 1 cycle; toggle_count=1. Release and press again → up_down=1, toggle_count=2.
- Bounce rejection, mode=0: btn pulses high 1, 2, then 3 cycles separated by 1-cycle lows → no toggle, toggle_count stays 0. Then hold high 6 cycles → exactly one toggle.
- Auto bounce, mode=1 driving the real counter from 0, up: count sequence 0..15,14..0,1..; no 15→0 or 0→15 transition; dir_changed coincident with count 15 and 0; toggle_count=2 after one full round trip.
- Simultaneous events, mode=1: time a debounced press to land on the cycle with count_in=14, up_down=1 → single flip to 0, toggle_count +1 only.
- Wrap and lock: force 256 toggles → toggle_count returns to 0. With DIR_CTRL_LOCK_EN, lock=1 plus a press → up_down unchanged, toggle_count unchanged.
